// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
//
// Shared definitions for the truth-table sweeper:
//   - state encoding localparams and the matching state enum
//   - case count / index width / settle counter width
//   - small helpers that turn a captured table into a mismatch mask and a
//     pass/fail flag
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

    // State encoding (2 bits)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Number of input cases for a 3-input block and the index width
    localparam int N_CASES = 8;
    localparam int IDX_W   = 3;

    // Settle counter width; covers SETTLE_CYCLES up to 15
    localparam int CNT_W   = 4;

    // Index of the final case in a sweep
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CASES - 1);

    typedef enum logic [1:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_SETTLE = ST_SETTLE,
        STATE_SAMPLE = ST_SAMPLE,
        STATE_DONE   = ST_DONE
    } state_t;

    // Per-case mismatch between an observed and an expected truth table
    function automatic logic [N_CASES-1:0] table_mismatch(
        input logic [N_CASES-1:0] observed,
        input logic [N_CASES-1:0] expected
    );
        return observed ^ expected;
    endfunction

    // A sweep fails if any case disagrees
    function automatic logic table_fail(input logic [N_CASES-1:0] mask);
        return |mask;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_settle_timer
//
// Counts the cycles a case has been held on the block under test.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   return the count to zero on the next edge (wins over en)
//   en   in   advance the count by one on the next edge
//   tc   out  high while the count equals SETTLE_CYCLES-1, i.e. in the last
//             settle cycle of the current case
// -----------------------------------------------------------------------------
module truth_table_sweeper_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Settle cycle counter: clear has priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == TC_VALUE);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Drives {A,B,C} through cases 0..7, waits SETTLE_CYCLES cycles per case,
// samples Y once per case and builds the observed truth table. At the end of
// the sweep the table is compared with EXPECTED.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   sweep request, only looked at while idle
//   y_in           in   Y of the block under test
//   a_out/b_out/c_out out  case drive, A is the MSB of the case index
//   case_idx       out  current case index = {a_out,b_out,c_out}
//   busy           out  high while settling/sampling
//   done           out  one-cycle pulse at sweep completion
//   table_out      out  observed Y per case (bit i = case i)
//   mismatch_mask  out  table_out ^ EXPECTED, valid from done onward
//   fail           out  any mismatch, valid from done onward
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                   SETTLE_CYCLES = 2,
    parameter logic [N_CASES-1:0]   EXPECTED      = 8'hE8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               y_in,
    output logic               a_out,
    output logic               b_out,
    output logic               c_out,
    output logic [IDX_W-1:0]   case_idx,
    output logic               busy,
    output logic               done,
    output logic [N_CASES-1:0] table_out,
    output logic [N_CASES-1:0] mismatch_mask,
    output logic               fail
);

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   case_idx_r;
    logic [N_CASES-1:0] table_r;
    logic [N_CASES-1:0] table_next_s;
    logic [N_CASES-1:0] mismatch_r;
    logic               fail_r;
    logic               busy_r;
    logic               done_r;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic               timer_tc_s;
    logic               accept_s;
    logic               last_case_s;

    assign last_case_s = (case_idx_r == LAST_IDX);

    truth_table_sweeper_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr_s),
        .en  (timer_en_s),
        .tc  (timer_tc_s)
    );

    // Next-state and settle timer control
    always_comb begin
        state_next_s = state_r;
        timer_clr_s  = 1'b0;
        timer_en_s   = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            STATE_IDLE: begin
                if (start) begin
                    state_next_s = STATE_SETTLE;
                    timer_clr_s  = 1'b1;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = STATE_IDLE;
                end
            end
            STATE_SETTLE: begin
                timer_en_s = 1'b1;
                // tc marks the last of the SETTLE_CYCLES settle cycles
                if (timer_tc_s) begin
                    state_next_s = STATE_SAMPLE;
                end else begin
                    state_next_s = STATE_SETTLE;
                end
            end
            STATE_SAMPLE: begin
                if (last_case_s) begin
                    state_next_s = STATE_DONE;
                end else begin
                    state_next_s = STATE_SETTLE;
                    timer_clr_s  = 1'b1;
                end
            end
            STATE_DONE: begin
                state_next_s = STATE_IDLE;
            end
            default: begin
                state_next_s = STATE_IDLE;
            end
        endcase
    end

    // Table with the current case's Y merged in; used on the sample cycle
    always_comb begin
        table_next_s             = table_r;
        table_next_s[case_idx_r] = y_in;
    end

    // State, index, capture and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= STATE_IDLE;
            case_idx_r <= {IDX_W{1'b0}};
            table_r    <= {N_CASES{1'b0}};
            mismatch_r <= {N_CASES{1'b0}};
            fail_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // busy/done follow the state being entered so they line up with it
            busy_r  <= (state_next_s == STATE_SETTLE) || (state_next_s == STATE_SAMPLE);
            done_r  <= (state_next_s == STATE_DONE);
            if (accept_s) begin
                case_idx_r <= {IDX_W{1'b0}};
                table_r    <= {N_CASES{1'b0}};
                mismatch_r <= {N_CASES{1'b0}};
                fail_r     <= 1'b0;
            end else if (state_r == STATE_SAMPLE) begin
                table_r <= table_next_s;
                if (last_case_s) begin
                    // Compare against the complete table so the result is
                    // already valid in the done cycle
                    mismatch_r <= table_mismatch(table_next_s, EXPECTED);
                    fail_r     <= table_fail(table_mismatch(table_next_s, EXPECTED));
                end else begin
                    case_idx_r <= case_idx_r + IDX_W'(1);
                end
            end else begin
                case_idx_r <= case_idx_r;
                table_r    <= table_r;
            end
        end
    end

    assign a_out         = case_idx_r[2];
    assign b_out         = case_idx_r[1];
    assign c_out         = case_idx_r[0];
    assign case_idx      = case_idx_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign table_out     = table_r;
    assign mismatch_mask = mismatch_r;
    assign fail          = fail_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweepers: dut0 with default parameters, dut1 with SETTLE_CYCLES=1.
// Each has its own Y model driven from its a/b/c outputs.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    localparam logic [7:0] EXP_TT = 8'hE8;

    localparam int M_MAJ  = 0;
    localparam int M_NMAJ = 1;
    localparam int M_ZERO = 2;
    localparam int M_XOR  = 3;
    localparam int M_TT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic y0, y1;
    logic a0, b0, c0, a1, b1, c1;
    logic [2:0] idx0, idx1;
    logic busy0, busy1, done0, done1, fail0, fail1;
    logic [7:0] tbl0, tbl1, mask0, mask1;

    int mode0 = M_MAJ;
    int mode1 = M_MAJ;
    logic [7:0] tt0 = 8'h00;
    logic [7:0] tt1 = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    truth_table_sweeper dut0 (
        .clk(clk), .rst(rst), .start(start0), .y_in(y0),
        .a_out(a0), .b_out(b0), .c_out(c0), .case_idx(idx0),
        .busy(busy0), .done(done0), .table_out(tbl0),
        .mismatch_mask(mask0), .fail(fail0)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .c_out(c1), .case_idx(idx1),
        .busy(busy1), .done(done1), .table_out(tbl1),
        .mismatch_mask(mask1), .fail(fail1)
    );

    // Behavioural block-under-test: Y as a function of the case number
    function automatic logic y_model(input int mode, input logic [7:0] tt, input logic [2:0] i);
        case (mode)
            M_MAJ:   return ($countones(i) >= 2);
            M_NMAJ:  return !($countones(i) >= 2);
            M_ZERO:  return 1'b0;
            M_XOR:   return ($countones(i) % 2) == 1;
            default: return tt[i];
        endcase
    endfunction

    always_comb y0 = y_model(mode0, tt0, {a0, b0, c0});
    always_comb y1 = y_model(mode1, tt1, {a1, b1, c1});

    // Selected-DUT view for the shared sweep task
    int sel = 0;
    logic m_done, m_busy, m_fail;
    logic [2:0] m_idx, m_abc;
    logic [7:0] m_tbl, m_mask;
    always_comb begin
        if (sel == 1) begin
            m_done = done1; m_busy = busy1; m_fail = fail1; m_idx = idx1;
            m_abc = {a1, b1, c1}; m_tbl = tbl1; m_mask = mask1;
        end else begin
            m_done = done0; m_busy = busy0; m_fail = fail0; m_idx = idx0;
            m_abc = {a0, b0, c0}; m_tbl = tbl0; m_mask = mask0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start0 = v;
    endtask

    // Results of the last sweep
    int r_lat, r_seq_err, r_busy_err, r_extra;
    logic [7:0] r_tbl, r_mask;
    logic r_fail;

    // Run one sweep on DUT s; optionally re-pulse start when case 4 is driven.
    // r_lat = cycles from the accepting edge to the cycle done is seen.
    task automatic run_sweep(input int s, input int sc, input bit restart, input int tail);
        int cyc;
        bit seen;
        bit pulsed;
        bit start_on;
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1 set_start(s, 1'b0);
        cyc = 0; seen = 0; pulsed = 0; start_on = 0;
        r_seq_err = 0; r_busy_err = 0; r_extra = 0;
        r_tbl = 8'h00; r_mask = 8'h00; r_fail = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (start_on) begin
                set_start(s, 1'b0);
                start_on = 0;
            end
            if (m_done) begin
                seen = 1;
                r_tbl = m_tbl; r_mask = m_mask; r_fail = m_fail;
                if (m_busy) r_busy_err++;
            end else begin
                if (m_idx != 3'((cyc - 1) / (sc + 1)) || m_abc != m_idx) r_seq_err++;
                if (!m_busy) r_busy_err++;
                if (restart && !pulsed && m_idx == 3'd4) begin
                    set_start(s, 1'b1);
                    pulsed = 1; start_on = 1;
                end
            end
        end
        r_lat = seen ? cyc : -1;
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            if (m_done) r_extra++;
        end
    endtask

    task automatic check_sweep(input string name, input int sc, input logic [7:0] e_tbl,
                               input logic [7:0] e_mask, input logic e_fail);
        check({name, "_latency"}, r_lat, 1 + 8 * (sc + 1));
        check({name, "_table"}, r_tbl, e_tbl);
        check({name, "_mask"}, r_mask, e_mask);
        check({name, "_fail"}, r_fail, e_fail);
        check({name, "_case_seq_errs"}, r_seq_err, 0);
        check({name, "_busy_errs"}, r_busy_err, 0);
        check({name, "_extra_done"}, r_extra, 0);
    endtask

    typedef struct {
        string      name;
        int         s;
        int         sc;
        int         mode;
        logic [7:0] e_tbl;
        logic [7:0] e_mask;
        logic       e_fail;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int cyc;
        bit seen;
        logic [7:0] tt;
        logic [7:0] e_tbl;
        int s;

        vecs[0] = '{"maj",       0, 2, M_MAJ,  8'hE8, 8'h00, 1'b0};
        vecs[1] = '{"not_maj",   0, 2, M_NMAJ, 8'h17, 8'hFF, 1'b1};
        vecs[2] = '{"zero",      0, 2, M_ZERO, 8'h00, 8'hE8, 1'b1};
        vecs[3] = '{"xor_sc1",   1, 1, M_XOR,  8'h96, 8'h7E, 1'b1};
        vecs[4] = '{"xor_sc2",   0, 2, M_XOR,  8'h96, 8'h7E, 1'b1};
        vecs[5] = '{"maj_sc1",   1, 1, M_MAJ,  8'hE8, 8'h00, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", {a0, b0, c0, idx0, busy0, done0, tbl0, mask0, fail0}, 32'h0);
        check("reset_dut1", {a1, b1, c1, idx1, busy1, done1, tbl1, mask1, fail1}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed truth tables
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].s == 1) mode1 = vecs[v].mode;
            else                mode0 = vecs[v].mode;
            run_sweep(vecs[v].s, vecs[v].sc, 1'b0, 2);
            check_sweep(vecs[v].name, vecs[v].sc, vecs[v].e_tbl, vecs[v].e_mask, vecs[v].e_fail);
        end

        // Results and last drive held while idle
        mode0 = M_MAJ;
        run_sweep(0, 2, 1'b0, 2);
        mode0 = M_ZERO;
        repeat (5) @(negedge clk);
        sel = 0;
        check("idle_hold_table", tbl0, 8'hE8);
        check("idle_hold_abc", {a0, b0, c0, busy0, done0}, {3'd7, 1'b0, 1'b0});

        // Random truth tables
        mode0 = M_TT; mode1 = M_TT;
        for (int r = 0; r < 8; r++) begin
            s  = int'($urandom_range(0, 1));
            tt = 8'($urandom);
            if (s == 1) tt1 = tt; else tt0 = tt;
            for (int i = 0; i < 8; i++) e_tbl[i] = y_model(M_TT, tt, 3'(i));
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            run_sweep(s, (s == 1) ? 1 : 2, 1'b0, 2);
            check_sweep("random", (s == 1) ? 1 : 2, e_tbl, e_tbl ^ EXP_TT, e_tbl != EXP_TT);
        end

        // start re-pulsed while busy on case 4
        mode0 = M_MAJ;
        run_sweep(0, 2, 1'b1, 30);
        check_sweep("restart_busy", 2, 8'hE8, 8'h00, 1'b0);

        // rst during SETTLE of case 3
        sel = 0;
        @(negedge clk);
        set_start(0, 1'b1);
        @(posedge clk);
        #1 set_start(0, 1'b0);
        cyc = 0;
        while (idx0 != 3'd3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_case3", idx0, 3'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midsweep_reset", {a0, b0, c0, idx0, busy0, done0, tbl0, mask0, fail0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) cyc++;
        end
        check("no_done_after_reset", cyc, 0);
        run_sweep(0, 2, 1'b0, 2);
        check_sweep("after_reset", 2, 8'hE8, 8'h00, 1'b0);

        // rst and start together: reset wins
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1;
        @(negedge clk);
        check("rst_and_start", {busy0, done0, idx0}, 32'h0);
        rst = 1'b0; start0 = 1'b0;
        @(negedge clk);
        check("rst_and_start_idle", busy0, 1'b0);

        // start during DONE is ignored; next IDLE cycle accepts it
        @(negedge clk);
        set_start(0, 1'b1);
        @(posedge clk);
        #1 set_start(0, 1'b0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done0) seen = 1;
        end
        check("done_seen", seen, 1'b1);
        set_start(0, 1'b1);
        @(negedge clk);
        check("start_in_done_ignored", {busy0, done0}, 2'b00);
        @(negedge clk);
        check("restart_from_idle", busy0, 1'b1);
        set_start(0, 1'b0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done0) seen = 1;
        end
        check("restart_done_latency", cyc, 24);
        check("restart_table", tbl0, 8'hE8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
